ifetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the I-memory.
- Owns the program counter and drives the memory read address.
- Tracks the memory's one-cycle registered read latency.
- Buffers fetched words in a 2-entry queue and presents them to decode with a valid/ready handshake.
- Handles branch redirects (flush) and halt.

---
 rtl/ifetch_ctrl.sv | 144 ++++++++++++++
 tb/tb_ifetch_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch sequencer. It owns the PC, tracks the one-cycle I-memory latency and feeds decode from a 2-entry queue.
// Optional build macro IFETCH_ZERO_HALT_EN: a captured all-zero word is delivered and then fetch halts.
`ifndef MEM_SPACE
`define MEM_SPACE 8
`endif
`ifndef ISIZE
`define ISIZE 16
`endif

// state | meaning
// BOOT  | first cycle after reset, memory output settling; no fetch, redirects held off
// RUN   | fetching one word per cycle while the queue has room
// HALT  | no fetch; in-flight word still captured, queue drains; only a redirect leaves
module ifetch_ctrl #(
  parameter int                ADDR_W    = `MEM_SPACE,
  parameter int                ISIZE     = `ISIZE,
  parameter logic [ADDR_W-1:0] BOOT_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [ISIZE-1:0]  imem_data,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_addr,
  input  logic              halt_req,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ISIZE-1:0]  inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              halted
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic [ISIZE-1:0]  q_data [2];
  logic [ADDR_W-1:0] q_pc   [2];
  logic [1:0]        occ;
  logic              head;
  logic              tail;

  logic       redir;
  logic       push;
  logic       pop;
  logic       issue;
  logic       zero_cap;
  logic [2:0] occ_proj;

  // A redirect is only honoured once out of BOOT; the requester keeps it asserted.
  assign redir    = redir_valid & (state != BOOT);
  assign push     = inflight & ~redir;
  assign pop      = inst_valid & inst_ready & ~redir;
  assign occ_proj = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign tail     = head ^ occ[0];

`ifdef IFETCH_ZERO_HALT_EN
  assign zero_cap = push & (imem_data == '0);
`else
  assign zero_cap = 1'b0;
`endif

  assign imem_addr  = pc;
  assign inst_valid = (occ != 2'd0);
  assign inst_out   = inst_valid ? q_data[head] : '0;
  assign inst_pc    = inst_valid ? q_pc[head]   : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (redir) begin
          state_nxt = RUN;
        end else if (halt_req || zero_cap) begin
          state_nxt = HALT;
        end
      end
      HALT: begin
        if (redir) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  // Issue is held back whenever the word could not fit once it lands.
  always_comb begin
    halted = (state == HALT);
    issue  = (state == RUN) & ~halt_req & ~redir_valid & ~zero_cap & (occ_proj < 3'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= BOOT_ADDR;
      inflight    <= 1'b0;
      inflight_pc <= BOOT_ADDR;
      occ         <= 2'd0;
      head        <= 1'b0;
    end else begin
      inflight    <= issue;
      inflight_pc <= pc;
      if (redir) begin
        pc <= redir_addr;
      end else if (issue) begin
        pc <= pc + 1'b1;
      end
      if (redir) begin
        occ  <= 2'd0;
        head <= 1'b0;
      end else begin
        occ <= occ + {1'b0, push} - {1'b0, pop};
        if (pop) begin
          head <= ~head;
        end
      end
    end
  end

  // Queue storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[tail] <= imem_data;
      q_pc[tail]   <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: scoreboard bench for ifetch_ctrl with a one-cycle registered I-memory model.
// Honours IFETCH_ZERO_HALT_EN when the design is built with it.
module tb_ifetch_ctrl;
  localparam int AW = 8;
  localparam int IW = 16;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_data;
  logic          redir_valid;
  logic [AW-1:0] redir_addr;
  logic          halt_req;
  logic          inst_valid;
  logic          inst_ready;
  logic [IW-1:0] inst_out;
  logic [AW-1:0] inst_pc;
  logic          halted;

  logic [IW-1:0] mem [256];
  exp_t          sb [$];
  exp_t          mon_e;
  int            passed = 0;
  int            total  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) imem_data <= '0;
    else     imem_data <= mem[imem_addr];
  end

  ifetch_ctrl #(.ADDR_W(AW), .ISIZE(IW), .BOOT_ADDR(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .redir_valid(redir_valid),
    .redir_addr (redir_addr),
    .halt_req   (halt_req),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .halted     (halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic expect_word(input logic [AW-1:0] p, input logic [IW-1:0] d);
    sb.push_back('{pc: p, data: d});
  endtask

  // Returns at the negedge of the first cycle showing inst_valid.
  task automatic wait_valid(input int bound, output int n);
    n = 0;
    neg();
    while (!inst_valid && n < bound) begin
      cyc();
      neg();
      n++;
    end
    if (!inst_valid) begin
      total++;
      $display("FAIL wait_valid: no inst_valid within %0d cycles", bound);
    end
  endtask

  // Redirect with decode stalled, let two words land, then drain exactly those two.
  task automatic redirect_fill(input logic [AW-1:0] target);
    cyc();
    redir_valid = 1'b1;
    redir_addr  = target;
    inst_ready  = 1'b0;
    cyc();
    redir_valid = 1'b0;
    repeat (4) cyc();
    neg();
  endtask

  task automatic drain_two();
    cyc();
    inst_ready = 1'b1;
    cyc();
    cyc();
    inst_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready && !redir_valid) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_pop: got pc %0h data %0h, required no delivery", inst_pc, inst_out);
      end else begin
        mon_e = sb.pop_front();
        chk("pop_pc", 32'(inst_pc), 32'(mon_e.pc));
        chk("pop_data", 32'(inst_out), 32'(mon_e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 16'h8000 | 16'(i);
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;
    mem[2] = 16'h3333;
    mem[3] = 16'h4444;
    rst = 1'b1;
    redir_valid = 1'b0;
    redir_addr = '0;
    halt_req = 1'b0;
    inst_ready = 1'b0;

    repeat (3) cyc();
    neg();
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_out", 32'(inst_out), 32'd0);
    chk("rst_pc", 32'(inst_pc), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);

    // Sustained streaming with decode always ready.
    cyc();
    rst = 1'b0;
    inst_ready = 1'b1;
    expect_word(8'h00, 16'h1111);
    expect_word(8'h01, 16'h2222);
    expect_word(8'h02, 16'h3333);
    expect_word(8'h03, 16'h4444);
    for (int i = 4; i < 8; i++) expect_word(8'(i), 16'h8000 | 16'(i));
    wait_valid(10, n);
    chk("first_valid_latency", 32'(n), 32'd3);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) neg();
      chk("no_gap_valid", 32'(inst_valid), 32'd1);
      cyc();
    end
    inst_ready = 1'b0;

    // Reset mid-stream discards queued and in-flight words.
    rst = 1'b1;
    cyc();
    cyc();
    neg();
    chk("rst2_valid", 32'(inst_valid), 32'd0);
    chk("rst2_addr", 32'(imem_addr), 32'd0);
    chk("sb_empty_after_stream", 32'(sb.size()), 32'd0);

    // Backpressure: queue fills, fetch address freezes, nothing lost.
    cyc();
    rst = 1'b0;
    expect_word(8'h00, 16'h1111);
    expect_word(8'h01, 16'h2222);
    expect_word(8'h02, 16'h3333);
    expect_word(8'h03, 16'h4444);
    wait_valid(10, n);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      neg();
      chk("stall_addr", 32'(imem_addr), 32'h02);
      chk("stall_head_pc", 32'(inst_pc), 32'h00);
    end
    cyc();
    inst_ready = 1'b1;
    repeat (4) cyc();
    inst_ready = 1'b0;
    repeat (2) cyc();
    neg();
    chk("full_valid", 32'(inst_valid), 32'd1);
    chk("full_head_pc", 32'(inst_pc), 32'h04);

    // Redirect flushes a full queue; halt with one word in flight.
    cyc();
    redir_valid = 1'b1;
    redir_addr = 8'h40;
    expect_word(8'h40, 16'h8040);
    cyc();
    redir_valid = 1'b0;
    neg();
    chk("flush_valid", 32'(inst_valid), 32'd0);
    chk("redir_addr_out", 32'(imem_addr), 32'h40);
    cyc();
    halt_req = 1'b1;
    cyc();
    halt_req = 1'b0;
    inst_ready = 1'b1;
    neg();
    chk("halt_inflight_valid", 32'(inst_valid), 32'd1);
    chk("halt_inflight_pc", 32'(inst_pc), 32'h40);
    chk("halt_state", 32'(halted), 32'd1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      neg();
      chk("halted_idle_valid", 32'(inst_valid), 32'd0);
      chk("halted_hold", 32'(halted), 32'd1);
    end
    chk("halted_addr", 32'(imem_addr), 32'h41);

    // Redirect out of HALT restarts at 0.
    expect_word(8'h00, 16'h1111);
    expect_word(8'h01, 16'h2222);
    redirect_fill(8'h00);
    chk("restart_halted", 32'(halted), 32'd0);
    chk("restart_head_pc", 32'(inst_pc), 32'h00);
    chk("restart_addr", 32'(imem_addr), 32'h02);
    drain_two();

    // PC wraps from the top of the address space.
    expect_word(8'hFF, 16'h80FF);
    expect_word(8'h00, 16'h1111);
    redirect_fill(8'hFF);
    chk("wrap_head_pc", 32'(inst_pc), 32'hFF);
    chk("wrap_addr", 32'(imem_addr), 32'h01);
    drain_two();

    // Zero word handling.
    mem[8'h20] = 16'hABCD;
    mem[8'h21] = 16'h0000;
    expect_word(8'h20, 16'hABCD);
    expect_word(8'h21, 16'h0000);
    redirect_fill(8'h20);
    chk("zero_head_pc", 32'(inst_pc), 32'h20);
`ifdef IFETCH_ZERO_HALT_EN
    chk("zero_halted_early", 32'(halted), 32'd1);
`else
    chk("zero_not_halted", 32'(halted), 32'd0);
`endif
    drain_two();
    repeat (2) cyc();
    neg();
`ifdef IFETCH_ZERO_HALT_EN
    chk("zero_after_valid", 32'(inst_valid), 32'd0);
    chk("zero_after_halted", 32'(halted), 32'd1);
`else
    chk("zero_after_valid", 32'(inst_valid), 32'd1);
    chk("zero_after_pc", 32'(inst_pc), 32'h22);
`endif

    cyc();
    chk("sb_empty_final", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
